aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 156 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//
// Sequences one AES-128 block through an external single-round datapath and
// an external round-key store. The sequencer holds the running cipher state,
// the current round key, the direction and the round counter. The round
// arithmetic itself lives outside, in the combinational rnd_* datapath.
//
// Encrypt: whitening key 0, then rounds 1..10; round 10 is final.
// Decrypt: whitening key 10, then rounds 9..0; round 0 is final.
// The decrypt datapath runs InvShiftRows, InvSubBytes, AddRoundKey and then
// InvMixColumns, so key index r is used directly.
//
// Handshakes (all ports): a transfer happens on a rising clk edge where both
// valid and ready (or key_req/key_valid) are high. The producer holds its
// payload stable until that edge. in_ready, out_valid and key_req come
// straight from the FSM state and never depend on the partner's signal.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          input block handshake
//   in_encrypt, in_data        direction and block, sampled at accept
//   out_valid/out_ready        result handshake, out_data = result
//   key_req/key_idx            round-key request and index 0..10
//   key_valid/key_in           round-key response
//   rnd_active .. rnd_key      one-cycle round evaluation request
//   rnd_result                 combinational datapath result
//   abort                      synchronous return to IDLE, highest priority
//   dbg_state                  current FSM state for observation
module aes_round_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_encrypt,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         key_req,
  output logic [3:0]   key_idx,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         rnd_active,
  output logic         rnd_encrypt,
  output logic         rnd_final,
  output logic [3:0]   rnd_num,
  output logic [127:0] rnd_data,
  output logic [127:0] rnd_key,
  input  logic [127:0] rnd_result,
  input  logic         abort,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WKEY = 3'd1,
    S_RKEY = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [3:0]   r;
  logic         dir_reg;
  logic         last_round;

  // The counter stops on the final round, so it never leaves 0..10.
  assign last_round = dir_reg ? (r == 4'd10) : (r == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    key_req    = 1'b0;
    key_idx    = 4'd0;
    rnd_active = 1'b0;
    rnd_final  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WKEY;
      end
      S_WKEY: begin
        key_req = 1'b1;
        key_idx = dir_reg ? 4'd0 : 4'd10;
        if (key_valid) state_nxt = S_RKEY;
      end
      S_RKEY: begin
        key_req = 1'b1;
        key_idx = r;
        if (key_valid) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        rnd_active = 1'b1;
        rnd_final  = last_round;
        state_nxt  = last_round ? S_DONE : S_RKEY;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort beats every handshake, including an accept in IDLE.
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      key_reg   <= '0;
      r         <= 4'd0;
      dir_reg   <= 1'b0;
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            state_reg <= in_data;
            dir_reg   <= in_encrypt;
            r         <= in_encrypt ? 4'd1 : 4'd9;
          end
        end
        S_WKEY: begin
          if (key_valid) state_reg <= state_reg ^ key_in;
        end
        S_RKEY: begin
          if (key_valid) key_reg <= key_in;
        end
        S_EXEC: begin
          state_reg <= rnd_result;
          if (!last_round) r <= dir_reg ? r + 4'd1 : r - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_data    = state_reg;
  assign rnd_data    = state_reg;
  assign rnd_key     = key_reg;
  assign rnd_encrypt = dir_reg;
  assign rnd_num     = r;
  assign dbg_state   = state;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: provides a behavioural AES round datapath
// and a round-key store with configurable wait cycles, and compares results
// against a whole-block AES reference model and the FIPS-197 C.1 vector.
module tb_aes_round_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_encrypt;
  logic [127:0] in_data;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         key_req, key_valid;
  logic [3:0]   key_idx;
  logic [127:0] key_in;
  logic         rnd_active, rnd_encrypt, rnd_final;
  logic [3:0]   rnd_num;
  logic [127:0] rnd_data, rnd_key, rnd_result;
  logic         abort;
  logic [2:0]   dbg_state;

  aes_round_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_encrypt(in_encrypt), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .key_req(key_req), .key_idx(key_idx), .key_valid(key_valid), .key_in(key_in),
    .rnd_active(rnd_active), .rnd_encrypt(rnd_encrypt), .rnd_final(rnd_final),
    .rnd_num(rnd_num), .rnd_data(rnd_data), .rnd_key(rnd_key), .rnd_result(rnd_result),
    .abort(abort), .dbg_state(dbg_state)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]  = s;
      isbox[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isbox[s[127-8*i -: 8]] : sbox[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*src) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   b;
    int           coef [4];
    if (inv) coef = '{14, 11, 13, 9};
    else     coef = '{2, 3, 1, 1};
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gm(s[127-8*(j+4*c) -: 8], 8'(coef[(j - i + 4) % 4]));
        o[127-8*(i+4*c) -: 8] = b;
      end
    return o;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [127:0] s;
    s = pt ^ round_key(key, 0);
    for (int r = 1; r <= 10; r++) begin
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
      if (r < 10) s = mix_columns(s, 1'b0);
      s = s ^ round_key(key, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_decrypt(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s;
    s = ct ^ round_key(key, 10);
    for (int r = 9; r >= 0; r--) begin
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ round_key(key, r);
      if (r > 0) s = mix_columns(s, 1'b1);
    end
    return s;
  endfunction

  function automatic logic [127:0] dp_round(input logic [127:0] d, input logic [127:0] k,
                                            input logic enc, input logic fin);
    logic [127:0] s;
    if (enc) begin
      s = shift_rows(sub_bytes(d, 1'b0), 1'b0);
      if (!fin) s = mix_columns(s, 1'b0);
      s = s ^ k;
    end else begin
      s = sub_bytes(shift_rows(d, 1'b1), 1'b1) ^ k;
      if (!fin) s = mix_columns(s, 1'b1);
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // External single-round datapath.
  always_comb rnd_result = dp_round(rnd_data, rnd_key, rnd_encrypt, rnd_final);

  // ---------------- key store model ----------------
  logic [127:0] rk_tbl [11];
  int           wait_lo = 0;
  int           wait_hi = 0;
  int           key_cnt = -1;
  int           total_waits = 0;
  logic [3:0]   req_idx;
  logic [3:0]   idx_q [$];

  task automatic load_key(input logic [127:0] key);
    for (int k = 0; k < 11; k++) rk_tbl[k] = round_key(key, k);
  endtask

  always @(negedge clk) begin
    if (rst || !key_req) begin
      key_valid = 1'b0;
      key_cnt   = -1;
    end else begin
      if (key_valid) begin
        key_valid = 1'b0;
        key_cnt   = -1;
      end
      if (key_cnt < 0) begin
        key_cnt = $urandom_range(wait_hi, wait_lo);
        req_idx = key_idx;
      end else begin
        check("key_idx_stable", {124'd0, key_idx}, {124'd0, req_idx});
      end
      if (key_cnt == 0) key_valid = 1'b1;
      else key_cnt--;
    end
    if (key_req && !key_valid) total_waits++;
    if (key_valid) begin
      key_in = rk_tbl[key_idx];
      idx_q.push_back(key_idx);
    end else begin
      key_in = rand128();
    end
  end

  // ---------------- round monitor ----------------
  typedef struct {
    logic [3:0]   num;
    logic         fin;
    logic         enc;
    logic [127:0] data;
    logic [127:0] key;
  } exec_t;
  exec_t exec_q [$];
  exec_t ex;

  always @(negedge clk) begin
    if (!rst) begin
      if (rnd_active) begin
        ex.num = rnd_num; ex.fin = rnd_final; ex.enc = rnd_encrypt;
        ex.data = rnd_data; ex.key = rnd_key;
        exec_q.push_back(ex);
      end else begin
        check("rnd_final_outside_exec", {127'd0, rnd_final}, 128'd0);
      end
      if (out_valid) check("key_req_in_done", {127'd0, key_req}, 128'd0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [$];

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic send_block(input logic [127:0] data, input logic enc);
    int k;
    k = 0;
    in_valid = 1'b1; in_data = data; in_encrypt = enc;
    while (in_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check("accept_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = rand128(); in_encrypt = ~enc;
    exec_q.delete(); idx_q.delete(); total_waits = 0;
  endtask

  task automatic wait_result(input logic enc, input int hold);
    int           k;
    logic [127:0] exp, held;
    exp = exp_q.size() > 0 ? exp_q.pop_front() : 128'h0;
    k = 0;
    do begin @(negedge clk); k++; end while (out_valid !== 1'b1 && k < 400);
    check("out_valid", {127'd0, out_valid}, 128'd1);
    check("latency", 128'(k), 128'(22 + total_waits));
    check("out_data", out_data, exp);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = rand128(); in_encrypt = 1'($urandom);
      @(negedge clk);
      check("hold_out_valid", {127'd0, out_valid}, 128'd1);
      check("hold_out_data", out_data, held);
      check("hold_in_ready", {127'd0, in_ready}, 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_hs_out_valid", {127'd0, out_valid}, 128'd0);
    check("post_hs_in_ready", {127'd0, in_ready}, 128'd1);
    in_valid = 1'b0;
    check("exec_count", 128'(exec_q.size()), 128'd10);
    check("idx_count", 128'(idx_q.size()), 128'd11);
    for (int i = 0; i < exec_q.size() && i < 10; i++) begin
      check($sformatf("rnd_num[%0d]", i), {124'd0, exec_q[i].num}, 128'(enc ? i + 1 : 9 - i));
      check($sformatf("rnd_final[%0d]", i), {127'd0, exec_q[i].fin}, {127'd0, i == 9});
      check($sformatf("rnd_encrypt[%0d]", i), {127'd0, exec_q[i].enc}, {127'd0, enc});
    end
    for (int i = 0; i < idx_q.size() && i < 11; i++)
      check($sformatf("key_idx[%0d]", i), {124'd0, idx_q[i]}, 128'(enc ? i : 10 - i));
  endtask

  task automatic wait_round(input logic [3:0] n);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!(rnd_active === 1'b1 && rnd_num === n) && k < 200);
    check("reach_round", {127'd0, rnd_active}, 128'd1);
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] key, pt;
  logic         enc, saw_ov;

  initial begin
    in_valid = 1'b0; in_encrypt = 1'b0; in_data = '0;
    out_ready = 1'b0; abort = 1'b0;
    build_sbox();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_key_req", {127'd0, key_req}, 128'd0);
    check("rst_rnd_active", {127'd0, rnd_active}, 128'd0);
    check("rst_rnd_final", {127'd0, rnd_final}, 128'd0);
    check("rst_key_idx", {124'd0, key_idx}, 128'd0);
    check("rst_rnd_num", {124'd0, rnd_num}, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_rnd_data", rnd_data, 128'd0);
    check("rst_rnd_key", rnd_key, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {127'd0, in_ready}, 128'd1);

    // FIPS-197 C.1 encrypt, zero-wait keys.
    load_key(C1_KEY);
    exp_q.push_back(C1_CT);
    send_block(C1_PT, 1'b1);
    wait_result(1'b1, 0);
    check("c1_r1_num", 128'(exec_q.size() > 0 ? exec_q[0].num : 4'hf), 128'd1);
    if (exec_q.size() > 0) begin
      check("c1_r1_data", exec_q[0].data, 128'h00102030405060708090a0b0c0d0e0f0);
      check("c1_r1_key", exec_q[0].key, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    end

    // C.1 decrypt.
    exp_q.push_back(C1_PT);
    send_block(C1_CT, 1'b0);
    wait_result(1'b0, 1);

    // C.1 encrypt with 3 wait cycles on every key request.
    wait_lo = 3; wait_hi = 3;
    exp_q.push_back(C1_CT);
    send_block(C1_PT, 1'b1);
    wait_result(1'b1, 0);
    check("c1_total_waits", 128'(total_waits), 128'd33);
    wait_lo = 0; wait_hi = 0;

    // Result held 5 cycles with a block offered; next accept right after.
    key = rand128(); load_key(key);
    pt = rand128();
    exp_q.push_back(aes_encrypt(pt, key));
    send_block(pt, 1'b1);
    wait_result(1'b1, 5);
    pt = rand128();
    exp_q.push_back(aes_decrypt(pt, key));
    send_block(pt, 1'b0);
    wait_result(1'b0, 0);

    // abort in round 4, then reset in round 7, then a clean block.
    send_block(rand128(), 1'b1);
    wait_round(4'd4);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {127'd0, in_ready}, 128'd1);
    check("abort_out_valid", {127'd0, out_valid}, 128'd0);
    check("abort_key_req", {127'd0, key_req}, 128'd0);
    send_block(rand128(), 1'b1);
    wait_round(4'd7);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_rnd_active", {127'd0, rnd_active}, 128'd0);
    check("midrst_out_data", out_data, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_ov = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) saw_ov = 1'b1;
    end
    check("no_out_valid_after_abort", {127'd0, saw_ov}, 128'd0);
    pt = rand128();
    exp_q.push_back(aes_decrypt(pt, key));
    send_block(pt, 1'b0);
    wait_result(1'b0, 0);

    // Random blocks, keys, directions and wait patterns.
    for (int n = 0; n < 6; n++) begin
      key = rand128(); load_key(key);
      pt = rand128();
      enc = 1'($urandom);
      wait_lo = 0; wait_hi = 3;
      exp_q.push_back(enc ? aes_encrypt(pt, key) : aes_decrypt(pt, key));
      send_block(pt, enc);
      wait_result(enc, $urandom_range(2, 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog state=%0d tests=%0d", dbg_state, tests);
    $fatal(1, "watchdog expired");
  end

endmodule
